// File: rtl/mem_arbiter.sv
// Byte-serial memory arbiter: one instruction-fetch port and one load/store port
// share a byte-wide synchronous RAM (one-cycle read latency).
module mem_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        rst_c,
   input  logic        inst_en_i,
   input  logic [31:0] inst_addr_i,
   output logic        inst_rdy_o,
   output logic [31:0] inst_data_o,
   input  logic        data_en_i,
   input  logic        data_rw_i,
   input  logic [2:0]  data_width_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_data_i,
   output logic        data_rdy_o,
   output logic [31:0] data_data_o,
   input  logic [7:0]  ram_din_i,
   output logic        ram_rw_o,
   output logic [31:0] ram_addr_o,
   output logic [7:0]  ram_data_o
);

   typedef enum logic [1:0] {IDLE, INST_RD, DATA_RD, DATA_WR} state_e;

   state_e      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        iss_q, iss_d;
   logic [2:0]  len_q, len_d;
   logic [31:0] base_q, base_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] buf_q, buf_d;
   logic        last_inst_q, last_inst_d;
   logic        inst_done_q, inst_done_d;
   logic        data_done_q, data_done_d;
   logic [31:0] inst_data_q, inst_data_d;
   logic [31:0] data_data_q, data_data_d;

   logic        inst_req, data_req;
   logic        gnt_inst, gnt_data;
   logic [2:0]  rd_idx;
   logic [2:0]  data_len;

   // A port is deaf to its own request in its done-pulse cycle; a flush kills fetch grants.
   assign inst_req = inst_en_i && !inst_done_q && !rst_c;
   assign data_req = data_en_i && !data_done_q;

   // While paused, keep presenting the uncaptured byte so its data is valid on resume.
   assign rd_idx = rdy ? (cnt_q + {2'b00, iss_q}) : cnt_q;

   assign data_len = (data_width_i == 3'd0) ? 3'd1 :
                     (data_width_i > 3'd4)  ? 3'd4 : data_width_i;

   assign inst_rdy_o  = inst_done_q && rdy && !rst_c;
   assign data_rdy_o  = data_done_q && rdy;
   assign inst_data_o = inst_data_q;
   assign data_data_o = data_data_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      iss_d       = iss_q;
      len_d       = len_q;
      base_d      = base_q;
      wdata_d     = wdata_q;
      buf_d       = buf_q;
      last_inst_d = last_inst_q;
      inst_done_d = inst_done_q;
      data_done_d = data_done_q;
      inst_data_d = inst_data_q;
      data_data_d = data_data_q;
      gnt_inst    = 1'b0;
      gnt_data    = 1'b0;
      ram_addr_o  = 32'd0;
      ram_data_o  = 8'd0;
      ram_rw_o    = 1'b0;

      if (rdy) begin
         inst_done_d = 1'b0;
         data_done_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (rdy) begin
               gnt_data = data_req && (!inst_req || last_inst_q);
               gnt_inst = inst_req && !gnt_data;
               // Round-robin bit only moves on a contested grant.
               if (data_req && inst_req) last_inst_d = gnt_inst;
               if (gnt_data || gnt_inst) begin
                  cnt_d = 3'd0;
                  iss_d = 1'b0;
                  buf_d = 32'd0;
               end
               if (gnt_data) begin
                  state_d = data_rw_i ? DATA_WR : DATA_RD;
                  base_d  = data_addr_i;
                  wdata_d = data_data_i;
                  len_d   = data_len;
               end else if (gnt_inst) begin
                  state_d = INST_RD;
                  base_d  = inst_addr_i;
                  len_d   = 3'd4;
               end
            end
         end

         INST_RD, DATA_RD: begin
            if (rd_idx < len_q) ram_addr_o = base_q + {29'd0, rd_idx};
            if (rdy) begin
               if (state_q == INST_RD && rst_c) begin
                  state_d = IDLE;
                  iss_d   = 1'b0;
               end else begin
                  iss_d = (rd_idx < len_q);
                  if (iss_q) begin
                     buf_d[{cnt_q[1:0], 3'b000} +: 8] = ram_din_i;
                     cnt_d = cnt_q + 3'd1;
                     if (cnt_q + 3'd1 == len_q) begin
                        state_d = IDLE;
                        iss_d   = 1'b0;
                        if (state_q == INST_RD) begin
                           inst_done_d = 1'b1;
                           inst_data_d = buf_d;
                        end else begin
                           data_done_d = 1'b1;
                           data_data_d = buf_d;
                        end
                     end
                  end
               end
            end
         end

         DATA_WR: begin
            ram_addr_o = base_q + {29'd0, cnt_q};
            ram_data_o = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
            ram_rw_o   = rdy;
            if (rdy) begin
               cnt_d = cnt_q + 3'd1;
               if (cnt_q + 3'd1 == len_q) begin
                  state_d     = IDLE;
                  data_done_d = 1'b1;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= 3'd0;
         iss_q       <= 1'b0;
         len_q       <= 3'd0;
         base_q      <= 32'd0;
         wdata_q     <= 32'd0;
         buf_q       <= 32'd0;
         last_inst_q <= 1'b1;
         inst_done_q <= 1'b0;
         data_done_q <= 1'b0;
         inst_data_q <= 32'd0;
         data_data_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         iss_q       <= iss_d;
         len_q       <= len_d;
         base_q      <= base_d;
         wdata_q     <= wdata_d;
         buf_q       <= buf_d;
         last_inst_q <= last_inst_d;
         inst_done_q <= inst_done_d;
         data_done_q <= data_done_d;
         inst_data_q <= inst_data_d;
         data_data_q <= data_data_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-wide synchronous RAM model.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy = 1'b1;
   logic        rst_c = 1'b0;
   logic        inst_en_i = 1'b0;
   logic [31:0] inst_addr_i = 32'd0;
   logic        inst_rdy_o;
   logic [31:0] inst_data_o;
   logic        data_en_i = 1'b0;
   logic        data_rw_i = 1'b0;
   logic [2:0]  data_width_i = 3'd0;
   logic [31:0] data_addr_i = 32'd0;
   logic [31:0] data_data_i = 32'd0;
   logic        data_rdy_o;
   logic [31:0] data_data_o;
   logic [7:0]  ram_din_i = 8'd0;
   logic        ram_rw_o;
   logic [31:0] ram_addr_o;
   logic [7:0]  ram_data_o;

   logic [7:0]  mem [0:262143];
   logic [39:0] wr_log[$];
   logic [31:0] rd_log[$];
   int          n_ipulse = 0;
   int          nvec = 0;
   int          nerr = 0;

   mem_arbiter dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rst_c(rst_c),
      .inst_en_i(inst_en_i), .inst_addr_i(inst_addr_i),
      .inst_rdy_o(inst_rdy_o), .inst_data_o(inst_data_o),
      .data_en_i(data_en_i), .data_rw_i(data_rw_i), .data_width_i(data_width_i),
      .data_addr_i(data_addr_i), .data_data_i(data_data_i),
      .data_rdy_o(data_rdy_o), .data_data_o(data_data_o),
      .ram_din_i(ram_din_i), .ram_rw_o(ram_rw_o),
      .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_rw_o) mem[ram_addr_o[17:0]] <= ram_data_o;
      ram_din_i <= mem[ram_addr_o[17:0]];
   end

   always @(negedge clk) begin
      if (ram_rw_o) wr_log.push_back({ram_addr_o, ram_data_o});
      else if (ram_addr_o != 32'd0) rd_log.push_back(ram_addr_o);
      if (inst_rdy_o) n_ipulse++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One request; t is the cycle offset from the request cycle (t=0).
   task automatic do_req(input bit is_inst, input bit rw, input logic [2:0] w,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int p_at, input int p_len, input int rc_from, input int rc_to,
                         output int lat, output logic [31:0] rd);
      bit flush = 1'b0;
      lat = -1;
      rd  = 32'd0;
      wr_log.delete();
      rd_log.delete();
      for (int t = 0; t <= 30 && lat < 0; t++) begin
         @(posedge clk); #1;
         if (t == 0) begin
            if (is_inst) begin
               inst_addr_i = a; inst_en_i = 1'b1;
            end else begin
               data_rw_i = rw; data_width_i = w; data_addr_i = a;
               data_data_i = wd; data_en_i = 1'b1;
            end
         end
         if (flush) inst_en_i = 1'b0;
         rdy   = !(p_len > 0 && t >= p_at && t < p_at + p_len);
         rst_c = (t >= rc_from && t <= rc_to);
         #1;
         if (is_inst ? inst_rdy_o : data_rdy_o) begin
            lat = t;
            rd  = is_inst ? inst_data_o : data_data_o;
         end
         if (is_inst && rst_c) flush = 1'b1;
      end
      inst_en_i = 1'b0;
      data_en_i = 1'b0;
      rdy       = 1'b1;
      rst_c     = 1'b0;
   endtask

   // Both ports request in the same cycle; records who got the bus first.
   task automatic do_pair(output logic [31:0] a1, output int ilat, output int dlat,
                          output logic [31:0] dd);
      ilat = -1; dlat = -1; a1 = 32'd0; dd = 32'd0;
      @(posedge clk); #1;
      inst_addr_i = 32'h100; inst_en_i = 1'b1;
      data_rw_i = 1'b0; data_width_i = 3'd1; data_addr_i = 32'h200; data_en_i = 1'b1;
      for (int t = 1; t <= 20 && (ilat < 0 || dlat < 0); t++) begin
         @(posedge clk); #2;
         if (t == 1) a1 = ram_addr_o;
         if (data_rdy_o && dlat < 0) begin dlat = t; dd = data_data_o; data_en_i = 1'b0; end
         if (inst_rdy_o && ilat < 0) begin ilat = t; inst_en_i = 1'b0; end
      end
      inst_en_i = 1'b0;
      data_en_i = 1'b0;
   endtask

   initial begin
      int          lat, ilat, dlat, bad, np;
      logic [31:0] rd, a1;

      for (int i = 0; i < 262144; i++) mem[i] = 8'(i * 7 + 3);
      mem[18'h100] = 8'h13; mem[18'h101] = 8'h05; mem[18'h102] = 8'h00; mem[18'h103] = 8'h00;
      mem[18'h200] = 8'h42;
      mem[18'h30000] = 8'h7E; mem[18'h30001] = 8'h99;

      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset ram_addr", ram_addr_o, 32'd0);
      chk("reset ram_rw/data", {23'd0, ram_rw_o, ram_data_o}, 32'd0);
      chk("reset rdy pulses", {30'd0, inst_rdy_o, data_rdy_o}, 32'd0);
      chk("reset inst_data", inst_data_o, 32'd0);
      chk("reset data_data", data_data_o, 32'd0);
      rst = 1'b1;

      // Contention from reset: data first, fetch granted in the data pulse cycle.
      do_pair(a1, ilat, dlat, rd);
      chk("pair1 first addr", a1, 32'h200);
      chk("pair1 data lat", dlat, 3);
      chk("pair1 inst lat", ilat, 9);
      chk("pair1 load data", rd, 32'h42);
      repeat (2) @(posedge clk);
      do_pair(a1, ilat, dlat, rd);
      chk("pair2 first addr", a1, 32'h100);
      chk("pair2 inst lat", ilat, 6);
      chk("pair2 data lat", dlat, 9);

      do_req(1, 0, 3'd4, 32'h100, 32'd0, 0, 0, -1, -2, lat, rd);
      chk("fetch lat", lat, 6);
      chk("fetch word", rd, 32'h00000513);
      chk("fetch nreads", rd_log.size(), 4);
      bad = 0;
      foreach (rd_log[i]) if (rd_log[i] != 32'h100 + i) bad++;
      chk("fetch addr seq", bad, 0);

      do_req(0, 1, 3'd2, 32'h2000, 32'hAABBCCDD, 0, 0, -1, -2, lat, rd);
      chk("st2 lat", lat, 3);
      chk("st2 nwrites", wr_log.size(), 2);
      if (wr_log.size() >= 2) begin
         chk("st2 write0", wr_log[0], {32'h2000, 8'hDD});
         chk("st2 write1", wr_log[1], {32'h2001, 8'hCC});
      end

      do_req(0, 0, 3'd2, 32'h2000, 32'd0, 0, 0, -1, -2, lat, rd);
      chk("ld2 lat", lat, 4);
      chk("ld2 data", rd, 32'h0000CCDD);

      do_req(0, 0, 3'd1, 32'h30000, 32'd0, 0, 0, -1, -2, lat, rd);
      chk("ld1 io lat", lat, 3);
      chk("ld1 io data", rd, 32'h0000007E);
      chk("ld1 io nreads", rd_log.size(), 1);

      do_req(1, 0, 3'd4, 32'h100, 32'd0, 3, 2, -1, -2, lat, rd);
      chk("pause lat", lat, 8);
      chk("pause word", rd, 32'h00000513);
      chk("pause nwrites", wr_log.size(), 0);
      bad = 0;
      foreach (rd_log[i]) if (rd_log[i] < 32'h100 || rd_log[i] > 32'h103) bad++;
      chk("pause addr range", bad, 0);

      do_req(1, 0, 3'd4, 32'h100, 32'd0, 0, 0, 3, 3, lat, rd);
      chk("flush busy no pulse", lat, -1);
      chk("flush busy nreads", rd_log.size(), 3);

      do_req(1, 0, 3'd4, 32'h100, 32'd0, 0, 0, 0, 0, lat, rd);
      chk("flush grant no pulse", lat, -1);
      chk("flush grant nreads", rd_log.size(), 0);

      do_req(0, 1, 3'd4, 32'h3000, 32'h11223344, 0, 0, 0, 30, lat, rd);
      chk("flush st4 lat", lat, 5);
      chk("flush st4 nwrites", wr_log.size(), 4);
      if (wr_log.size() >= 4) chk("flush st4 write3", wr_log[3], {32'h3003, 8'h11});

      do_req(1, 0, 3'd4, 32'h100, 32'd0, 0, 0, 6, 6, lat, rd);
      chk("flush at pulse", lat, -1);

      do_req(1, 0, 3'd4, 32'h3000, 32'd0, 0, 0, -1, -2, lat, rd);
      chk("fetch after store lat", lat, 6);
      chk("fetch after store word", rd, 32'h11223344);

      // Asynchronous reset in the middle of a fetch.
      @(posedge clk); #1;
      inst_addr_i = 32'h100; inst_en_i = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("midrst ram_addr", ram_addr_o, 32'd0);
      chk("midrst inst_data", inst_data_o, 32'd0);
      chk("midrst pulses", {30'd0, inst_rdy_o, data_rdy_o}, 32'd0);
      inst_en_i = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      np = n_ipulse;
      repeat (10) @(posedge clk);
      #1;
      chk("midrst no stray pulse", n_ipulse - np, 0);
      chk("midrst idle addr", ram_addr_o, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
